// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types, default sizes and the round-robin helper for fifo_wr_arbiter.
`default_nettype none

package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_MAX_BURST  = 4;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int CNT_W          = 16;
  localparam int RR_MAX         = 8;

  // First set bit of mask strictly after last, wrapping modulo n; last itself is checked last.
  function automatic logic [2:0] rr_next(input logic [2:0] last, input logic [7:0] mask, input int n);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= RR_MAX; k++) begin
      idx = (int'(last) + k) % n;
      if (!found && (k <= n) && mask[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// rr_picker: combinational round-robin winner selection over the request mask.
`default_nettype none

module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] last_owner,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [7:0] mask8;
  logic [2:0] last3;

  assign mask8  = 8'(req_valid);
  assign last3  = 3'(last_owner);
  assign winner = ID_W'(rr_next(last3, mask8, NUM_REQ));
  assign any    = |req_valid;

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-granular sharing of a FIFO write port with full/almostfull
// throttling and write-response monitoring.
`default_nettype none

module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic                          grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic [CNT_W-1:0]              beat_cnt_total,
  output logic [CNT_W-1:0]              ack_cnt_total,
  output logic                          ovf_err
);

  localparam int ID_W   = $clog2(NUM_REQ);
  // A burst never exceeds the FIFO depth, so this width always holds the beat count.
  localparam int BEAT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

  arb_state_e          state;
  arb_state_e          state_next;
  logic [ID_W-1:0]     last_owner;
  logic [ID_W-1:0]     pick_id;
  logic                pick_any;
  logic [BEAT_W-1:0]   beat_cnt;
  logic                can_issue;
  logic                owner_valid;
  logic                burst_end;
  logic                accept;
  logic                release_grant;
  logic [DATA_WIDTH-1:0] owner_data;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_valid  (req_valid),
    .last_owner (last_owner),
    .winner     (pick_id),
    .any        (pick_any)
  );

  // Exact occupancy bound: a write in flight at almostfull would fill the FIFO.
  assign can_issue   = !fifo_full && !(fifo_almostfull && fifo_wr_en);
  assign owner_valid = req_valid[grant_id];
  assign owner_data  = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign burst_end   = req_last[grant_id] || (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    req_ready     = '0;
    accept        = 1'b0;
    release_grant = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_next = OWN;
        end
      end
      OWN: begin
        req_ready[grant_id] = can_issue;
        if (owner_valid && can_issue) begin
          accept = 1'b1;
          if (burst_end) begin
            release_grant = 1'b1;
            state_next    = IDLE;
          end
        end else if (!owner_valid) begin
          release_grant = 1'b1;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_valid    <= 1'b0;
      grant_id       <= '0;
      last_owner     <= ID_W'(NUM_REQ - 1);
      beat_cnt       <= '0;
      fifo_wr_en     <= 1'b0;
      fifo_data_in   <= '0;
      beat_cnt_total <= '0;
    end else begin
      fifo_wr_en <= accept;
      if (accept) begin
        fifo_data_in   <= owner_data;
        beat_cnt       <= beat_cnt + 1'b1;
        beat_cnt_total <= beat_cnt_total + 1'b1;
      end
      if ((state == IDLE) && pick_any) begin
        grant_id    <= pick_id;
        grant_valid <= 1'b1;
        beat_cnt    <= '0;
      end
      if (release_grant) begin
        last_owner  <= grant_id;
        grant_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_cnt_total <= '0;
      ovf_err       <= 1'b0;
    end else begin
      if (fifo_wr_ack) begin
        ack_cnt_total <= ack_cnt_total + 1'b1;
      end
      if (fifo_overflow) begin
        ovf_err <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed self-checking bench with a small FIFO occupancy model.
`default_nettype none

module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_last = '0;
  logic [15:0] d [4];
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_wr_en;
  logic [15:0] fifo_data_in;
  logic        fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic [15:0] beat_cnt_total, ack_cnt_total;
  logic        ovf_err;

  // FIFO occupancy model driving the flags and write responses
  logic [3:0] count = 4'd0;
  logic       preset_en = 1'b0;
  logic [3:0] preset_val = 4'd0;
  logic       rd = 1'b0;
  logic       force_ovf = 1'b0;
  logic       model_ack = 1'b0;
  logic       model_ovf = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign req_data        = {d[3], d[2], d[1], d[0]};
  assign fifo_full       = (count == 4'd8);
  assign fifo_almostfull = (count == 4'd7);
  assign fifo_wr_ack     = model_ack;
  assign fifo_overflow   = model_ovf | force_ovf;

  always @(posedge clk) begin
    if (preset_en) count <= preset_val;
    else count <= count + ((fifo_wr_en && count != 4'd8) ? 4'd1 : 4'd0)
                        - ((rd && count != 4'd0) ? 4'd1 : 4'd0);
    model_ack <= fifo_wr_en && (count != 4'd8);
    model_ovf <= fifo_wr_en && (count == 4'd8);
  end

  fifo_wr_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(16), .MAX_BURST(4), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .fifo_full(fifo_full), .fifo_almostfull(fifo_almostfull),
    .fifo_wr_ack(fifo_wr_ack), .fifo_overflow(fifo_overflow),
    .grant_valid(grant_valid), .grant_id(grant_id),
    .beat_cnt_total(beat_cnt_total), .ack_cnt_total(ack_cnt_total),
    .ovf_err(ovf_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preset(input logic [3:0] v);
    preset_en  = 1'b1;
    preset_val = v;
    tick();
    preset_en  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(fifo_wr_en), 32'd0);
    chk({tag, "_data"}, 32'(fifo_data_in), 32'd0);
    chk({tag, "_gvalid"}, 32'(grant_valid), 32'd0);
    chk({tag, "_gid"}, 32'(grant_id), 32'd0);
    chk({tag, "_beats"}, 32'(beat_cnt_total), 32'd0);
    chk({tag, "_acks"}, 32'(ack_cnt_total), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf_err), 32'd0);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) d[i] = 16'h0;
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Round-robin: every producer valid with single-beat bursts
    req_valid = 4'hF;
    req_last  = 4'hF;
    for (int i = 0; i < 4; i++) d[i] = 16'hA000 + 16'(i);
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("rr_gid", 32'(grant_id), 32'(g % 4));
      chk("rr_gvalid", 32'(grant_valid), 32'd1);
      chk("rr_ready", 32'(req_ready), 32'(1 << (g % 4)));
      chk("rr_idle_wr", 32'(fifo_wr_en), 32'd0);
      tick();
      chk("rr_wr_en", 32'(fifo_wr_en), 32'd1);
      chk("rr_data", 32'(fifo_data_in), 32'hA000 + 32'(g % 4));
      chk("rr_release", 32'(grant_valid), 32'd0);
    end
    chk("rr_beats", 32'(beat_cnt_total), 32'd5);
    req_valid = 4'h0;
    tick(); tick(); tick();
    chk("rr_acks", 32'(ack_cnt_total), 32'd5);

    // MAX_BURST: producer 2 streams without last, producer 3 waiting
    preset(4'd0);
    req_valid = 4'b1100;
    req_last  = 4'b1000;
    d[2] = 16'hB000;
    d[3] = 16'hC000;
    tick();
    chk("mb_gid", 32'(grant_id), 32'd2);
    for (int b = 0; b < 4; b++) begin
      tick();
      chk("mb_wr_en", 32'(fifo_wr_en), 32'd1);
      chk("mb_data", 32'(fifo_data_in), 32'hB000 + 32'(b));
      d[2] = 16'hB000 + 16'(b + 1);
    end
    chk("mb_end", 32'(grant_valid), 32'd0);
    tick();
    chk("mb_next_gid", 32'(grant_id), 32'd3);
    chk("mb_gap_wr", 32'(fifo_wr_en), 32'd0);
    tick();
    chk("mb_p3_data", 32'(fifo_data_in), 32'hC000);
    req_valid = 4'h0;
    tick(); tick(); tick();
    chk("mb_beats", 32'(beat_cnt_total), 32'd10);
    chk("mb_acks", 32'(ack_cnt_total), 32'd10);

    // Full throttle from count 6
    preset(4'd6);
    req_valid = 4'b0001;
    req_last  = 4'b0000;
    d[0] = 16'hD000;
    tick();
    chk("ft_gid", 32'(grant_id), 32'd0);
    chk("ft_ready0", 32'(req_ready), 32'd1);
    tick();
    chk("ft_wr1", 32'(fifo_wr_en), 32'd1);
    chk("ft_data1", 32'(fifo_data_in), 32'hD000);
    chk("ft_ready1", 32'(req_ready), 32'd1);
    d[0] = 16'hD001;
    tick();
    chk("ft_wr2", 32'(fifo_wr_en), 32'd1);
    chk("ft_data2", 32'(fifo_data_in), 32'hD001);
    chk("ft_block_af", 32'(req_ready), 32'd0);
    d[0] = 16'hD002;
    tick();
    chk("ft_stall_wr", 32'(fifo_wr_en), 32'd0);
    chk("ft_stall_ready", 32'(req_ready), 32'd0);
    chk("ft_hold_grant", 32'(grant_valid), 32'd1);
    tick(); tick();
    chk("ft_full_ready", 32'(req_ready), 32'd0);
    chk("ft_acks", 32'(ack_cnt_total), 32'd12);
    chk("ft_no_ovf", 32'(ovf_err), 32'd0);
    chk("ft_beats", 32'(beat_cnt_total), 32'd12);

    // Drain recovery: one read from full
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("dr_ready", 32'(req_ready), 32'd1);
    tick();
    chk("dr_wr", 32'(fifo_wr_en), 32'd1);
    chk("dr_data", 32'(fifo_data_in), 32'hD002);
    chk("dr_block", 32'(req_ready), 32'd0);
    tick();
    chk("dr_stall_wr", 32'(fifo_wr_en), 32'd0);
    tick();
    chk("dr_stall_ready", 32'(req_ready), 32'd0);
    chk("dr_beats", 32'(beat_cnt_total), 32'd13);

    // Overflow monitor: sticky error
    force_ovf = 1'b1;
    tick();
    force_ovf = 1'b0;
    chk("ovf_set", 32'(ovf_err), 32'd1);
    tick(); tick();
    chk("ovf_sticky", 32'(ovf_err), 32'd1);
    chk("ovf_acks", 32'(ack_cnt_total), 32'd13);

    // Asynchronous reset in the middle of an owned burst
    chk("rst_pre_grant", 32'(grant_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_async");
    req_valid = 4'hF;
    req_last  = 4'hF;
    for (int i = 0; i < 4; i++) d[i] = 16'hE000 + 16'(i);
    preset(4'd0);
    rst_n = 1'b1;
    tick();
    chk("post_gid", 32'(grant_id), 32'd0);
    chk("post_gvalid", 32'(grant_valid), 32'd1);
    chk("post_ready", 32'(req_ready), 32'd1);
    tick();
    chk("post_data", 32'(fifo_data_in), 32'hE000);
    chk("post_beats", 32'(beat_cnt_total), 32'd1);
    tick();
    chk("post_next_gid", 32'(grant_id), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Shares the write port of the synchronous FIFO among `NUM_REQ` producers using round-robin, burst-granular arbitration. It drives the FIFO's `wr_en`/`data_in` from registers. It throttles on the FIFO's `full`/`almostfull` flags so that, in normal operation, a write is never issued into a full FIFO. It also monitors `wr_ack`/`overflow` for status. The block sits between the producer agents and the FIFO `wr_*` pins; the read side is not touched.

## Interface
- `NUM_REQ`, 4: number of producers (2..8).
- `DATA_WIDTH`, 16: FIFO word width.
- `MAX_BURST`, 4: maximum beats per grant (1..FIFO_DEPTH).
- `FIFO_DEPTH`, 8: depth of the attached FIFO (status only).
- `clk`  in  1  clock; everything is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  NUM_REQ  producer i has a word.
- `req_last`  in  NUM_REQ  producer i's current word ends its burst.
- `req_data`  in  NUM_REQ*DATA_WIDTH  producer i's word in slice [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ  combinational; word accepted at the edge where valid && ready.
- `fifo_wr_en`  out  1  registered write strobe to the FIFO.
- `fifo_data_in`  out  DATA_WIDTH  registered write data.
- `fifo_full`, `fifo_almostfull`  in  1  FIFO flags (count==DEPTH, count==DEPTH-1).
- `fifo_wr_ack`, `fifo_overflow`  in  1  FIFO write responses, valid the cycle after the FIFO samples `wr_en`.
- `grant_valid`  out  1  a burst owner exists.
- `grant_id`  out  $clog2(NUM_REQ)  current owner.
- `beat_cnt_total`  out  16  accepted beats, wraps.
- `ack_cnt_total`  out  16  `fifo_wr_ack` pulses, wraps.
- `ovf_err`  out  1  sticky; set on any `fifo_overflow`, cleared only by reset.

## Operation
- FSM states are IDLE and OWN.
- **IDLE**
  - `req_ready` = 0.
  - If any `req_valid`: the round-robin picker selects the first requester after `last_owner` (wrapping). Register it as `grant_id`, set `grant_valid`, go to OWN, clear `beat_cnt`.
- **OWN**
  - `req_ready[grant_id]` = `can_issue`; all other ready bits are 0.
  - `can_issue` = !`fifo_full` && !(`fifo_almostfull` && `fifo_wr_en`). This is exact: reads only lower the count.
  - On an accepted beat:
    - `fifo_wr_en`<=1, `fifo_data_in`<=word.
    - `beat_cnt`++ and `beat_cnt_total`++.
    - If `req_last` or `beat_cnt`==MAX_BURST-1: go to IDLE, `last_owner`<=`grant_id`, `grant_valid`<=0.
  - If the owner's `req_valid` is 0: go to IDLE and release as above. This avoids a stalled owner blocking others.
  - If `can_issue`=0: stay in OWN and hold the grant; `fifo_wr_en`<=0.
- `fifo_wr_en`<=0 on every cycle without an accepted beat.
- Monitor:
  - `ack_cnt_total`++ on `fifo_wr_ack`.
  - `ovf_err`<=1 on `fifo_overflow`. The word is not replayed.
- Reset values: state IDLE, `last_owner`=NUM_REQ-1 (requester 0 wins first), all outputs 0.
- A mid-burst reset drops the burst; no partial state survives.

## Timing
- Arbitration latency is 1 cycle: `req_valid` rising in IDLE at cycle t gives the first possible acceptance at t+1.
- Acceptance at edge t: `fifo_wr_en`=1 during t+1, the FIFO writes at the end of t+1, and `fifo_wr_ack` is visible in t+2.
- Back-to-back beats are allowed: full throughput within a burst.
- Burst gap: at least 1 IDLE cycle between bursts.
- Full boundary:
  - Count=7 with `fifo_wr_en`=1 blocks the next issue.
  - Count=6 with `fifo_wr_en`=1 allows one more issue.
  - Counter wrap is 16-bit modulo.

## Structure
- `fifo_arb_pkg` holds:
  - state enum `arb_state_e` {IDLE, OWN};
  - `localparam` default widths;
  - function `rr_next(last, mask)`.
- Sub-module `rr_picker` (combinational): inputs are the `req_valid` mask and `last_owner`; outputs are `winner` and `any`.
- The top level holds the FSM, beat counter, output registers and monitors.

## Test plan
- **Round-robin:** all 4 producers continuously valid, each `req_last`=1 → grants 0,1,2,3,0 in order. One `fifo_wr_en` every 2 cycles; `beat_cnt_total`=5 after 5 grants.
- **MAX_BURST:** producer 2 streams 6 words with `req_last` low → burst ends after 4 accepted beats, FSM returns to IDLE. If producer 3 is valid it is granted next; otherwise producer 2 is re-granted.
- **Full throttle:** FIFO count=6, no reads, producer 0 streams → exactly 2 writes accepted and `req_ready` held low afterward. `fifo_full`=1, `ovf_err` stays 0, `ack_cnt_total`=2.
- **Drain recovery:** from full, a read drops the count to 7 → exactly one more beat accepted, then stall.
- **Overflow monitor:** force `fifo_overflow`=1 for one cycle → `ovf_err`=1 and stays 1 until `rst_n` is asserted.
- **Reset mid-burst:** assert `rst_n`=0 asynchronously mid-cycle during a burst → all outputs 0 immediately. After release, requester 0 wins first arbitration.
